uart_boot_loader: RTL and testbench

Downstream consumer of the UART receiver: takes each received byte (`rxData` plus completion strobe `rxFin`) and parses a framed boot image. It assembles the image into 32-bit little-endian words and writes them to instruction/data memory through a ready-handshaked write port. It holds the CPU in reset until the whole image has been written and a checksum has verified.

---
 rtl/uart_boot_loader.sv | 143 ++++++++++++++
 tb/tb_uart_boot_loader.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_boot_loader.sv
// Parses a framed boot image from the UART receiver, writes it to memory as
// little-endian words and releases the CPU once the checksum has verified.
module uart_boot_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 4096
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  rxData,
  input  logic        rxFin,
  input  logic        memReady,
  output logic        memWriteEnable,
  output logic [31:0] memAddress,
  output logic [31:0] memWriteData,
  output logic        cpuHold,
  output logic        loading,
  output logic        done,
  output logic        error,
  output logic [1:0]  errorCode
);

  localparam int IDXW = $clog2(MAX_WORDS + 1);

  typedef enum logic [2:0] {LEN, DATA, WRITE, CHECK, DONE, ERR} stateType;

  stateType         state, nextState;
  logic             rxSync1, rxSync2, rxSync3;
  logic             byteStrobe;
  logic [1:0]       byteCount;
  logic [23:0]      lenLow;
  logic [31:0]      lenFull;
  logic [IDXW-1:0]  wordCount;
  logic [IDXW-1:0]  wordIndex;
  logic [IDXW-1:0]  wordNext;
  logic [31:0]      wordReg;
  logic [7:0]       xorReg;
  logic [1:0]       errCodeReg;
  logic [1:0]       nextCode;

  // Flops idle high so an rxFin already asserted at reset release is not seen as a new edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rxSync1 <= 1'b1;
      rxSync2 <= 1'b1;
      rxSync3 <= 1'b1;
    end else begin
      rxSync1 <= rxFin;
      rxSync2 <= rxSync1;
      rxSync3 <= rxSync2;
    end
  end

  assign byteStrobe = rxSync2 & ~rxSync3;
  assign lenFull    = {rxData, lenLow};
  assign wordNext   = wordIndex + 1'b1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= LEN;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    nextCode  = 2'd0;
    case (state)
      LEN: begin
        if (byteStrobe && byteCount == 2'd3) begin
          if (lenFull > 32'(MAX_WORDS)) begin
            nextState = ERR;
            nextCode  = 2'd1;
          end else if (lenFull == 32'd0) begin
            nextState = CHECK;
          end else begin
            nextState = DATA;
          end
        end
      end
      DATA: begin
        if (byteStrobe && byteCount == 2'd3) nextState = WRITE;
      end
      WRITE: begin
        // A byte arriving before the write is accepted means the memory fell behind the link.
        if (byteStrobe) begin
          nextState = ERR;
          nextCode  = 2'd2;
        end else if (memReady) begin
          nextState = (wordNext == wordCount) ? CHECK : DATA;
        end
      end
      CHECK: begin
        if (byteStrobe) begin
          if (rxData == xorReg) begin
            nextState = DONE;
          end else begin
            nextState = ERR;
            nextCode  = 2'd3;
          end
        end
      end
      default: nextState = state;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      byteCount  <= 2'd0;
      lenLow     <= 24'd0;
      wordCount  <= '0;
      wordIndex  <= '0;
      wordReg    <= 32'd0;
      xorReg     <= 8'd0;
      errCodeReg <= 2'd0;
    end else begin
      if (byteStrobe && (state == LEN || state == DATA)) begin
        xorReg    <= xorReg ^ rxData;
        byteCount <= byteCount + 2'd1;
      end
      if (byteStrobe && state == LEN) begin
        if (byteCount == 2'd3) wordCount <= lenFull[IDXW-1:0];
        else                   lenLow    <= {rxData, lenLow[23:8]};
      end
      if (byteStrobe && state == DATA) wordReg <= {rxData, wordReg[31:8]};
      if (state == WRITE && memReady && !byteStrobe) wordIndex <= wordNext;
      if (nextState == ERR && state != ERR) errCodeReg <= nextCode;
    end
  end

  always_comb begin
    memWriteEnable = (state == WRITE);
    memAddress     = 32'd0;
    memWriteData   = 32'd0;
    if (state == WRITE) begin
      memAddress   = BASE_ADDR + (32'(wordIndex) << 2);
      memWriteData = wordReg;
    end
    cpuHold   = (state != DONE);
    loading   = (state == LEN) || (state == DATA) || (state == WRITE) || (state == CHECK);
    done      = (state == DONE);
    error     = (state == ERR);
    errorCode = errCodeReg;
  end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Scoreboard bench for uart_boot_loader: a byte-level image model predicts the
// memory writes and the final status; a monitor checks every accepted write.
module tb_uart_boot_loader;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int          MAXW = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  rxData = 8'h00;
  logic        rxFin = 1'b0;
  logic        memReady = 1'b1;
  logic        memWriteEnable;
  logic [31:0] memAddress;
  logic [31:0] memWriteData;
  logic        cpuHold;
  logic        loading;
  logic        done;
  logic        error;
  logic [1:0]  errorCode;

  uart_boot_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .clock(clock),
    .reset(reset),
    .rxData(rxData),
    .rxFin(rxFin),
    .memReady(memReady),
    .memWriteEnable(memWriteEnable),
    .memAddress(memAddress),
    .memWriteData(memWriteData),
    .cpuHold(cpuHold),
    .loading(loading),
    .done(done),
    .error(error),
    .errorCode(errorCode)
  );

  always #5 clock = ~clock;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] sb[$];
  int          waitLog[$];
  logic [7:0]  imgBytes[$];
  int          readyMode = 0;
  int          lowRun = 0;

  logic [7:0] goodImg [13] = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                               8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h28};

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory side: mode 0 random stalls of at most 3 cycles, 1 never ready, 2 stall first write 3 cycles.
  always @(posedge clock) begin
    #1;
    case (readyMode)
      0: begin
        if (memWriteEnable && lowRun < 3 && $urandom_range(0, 1) == 1) begin
          memReady = 1'b0;
          lowRun++;
        end else begin
          memReady = 1'b1;
          lowRun = 0;
        end
      end
      1: memReady = 1'b0;
      default: begin
        if (memWriteEnable && lowRun < 3) begin
          memReady = 1'b0;
          lowRun++;
        end else begin
          memReady = 1'b1;
        end
      end
    endcase
  end

  logic        stallActive = 1'b0;
  logic [31:0] stallAddr, stallData;
  logic [63:0] expW;
  int          weCycles = 0;

  // Write monitor: compares each accepted write against the scoreboard head.
  always @(negedge clock) begin
    if (!reset) begin
      stallActive = 1'b0;
      weCycles = 0;
    end else if (memWriteEnable) begin
      weCycles++;
      if (stallActive) begin
        checkVal("stall_addr", memAddress, stallAddr);
        checkVal("stall_data", memWriteData, stallData);
      end
      if (memReady) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                   memAddress, memWriteData);
        end else begin
          expW = sb.pop_front();
          checkVal("write_addr", memAddress, expW[63:32]);
          checkVal("write_data", memWriteData, expW[31:0]);
        end
        waitLog.push_back(weCycles);
        weCycles = 0;
        stallActive = 1'b0;
      end else begin
        stallActive = 1'b1;
        stallAddr = memAddress;
        stallData = memWriteData;
      end
    end else begin
      stallActive = 1'b0;
      weCycles = 0;
    end
  end

  task automatic doReset();
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    sb.delete();
    waitLog.delete();
    repeat (2) @(negedge clock);
  endtask

  task automatic sendByte(input logic [7:0] b);
    @(negedge clock);
    rxData = b;
    rxFin = 1'b1;
    repeat (4) @(negedge clock);
    rxFin = 1'b0;
    repeat (5) @(negedge clock);
  endtask

  task automatic applyStimulus();
    foreach (imgBytes[i]) sendByte(imgBytes[i]);
  endtask

  // Reference model: decodes the frame by its byte layout and predicts writes and outcome.
  task automatic modelImage(output logic expDone, output logic expErr, output logic [1:0] expCode);
    logic [31:0] n;
    logic [7:0]  x;
    int          nw;
    expDone = 1'b0;
    expErr  = 1'b0;
    expCode = 2'd0;
    n = {imgBytes[3], imgBytes[2], imgBytes[1], imgBytes[0]};
    if (n > 32'(MAXW)) begin
      expErr  = 1'b1;
      expCode = 2'd1;
      return;
    end
    nw = int'(n);
    for (int i = 0; i < nw; i++)
      sb.push_back({BASE + 32'(4 * i), imgBytes[4*i+7], imgBytes[4*i+6], imgBytes[4*i+5], imgBytes[4*i+4]});
    x = 8'h00;
    for (int i = 0; i < 4 * nw + 4; i++) x = x ^ imgBytes[i];
    if (x == imgBytes[4*nw+4]) begin
      expDone = 1'b1;
    end else begin
      expErr  = 1'b1;
      expCode = 2'd3;
    end
  endtask

  task automatic checkOutput(input string name, input logic expDone, input logic expErr,
                             input logic [1:0] expCode);
    repeat (3) @(negedge clock);
    checkVal({name, "_done"}, done, expDone);
    checkVal({name, "_error"}, error, expErr);
    checkVal({name, "_code"}, errorCode, expCode);
    checkVal({name, "_cpuHold"}, cpuHold, !expDone);
    checkVal({name, "_loading"}, loading, !(expDone || expErr));
    checkVal({name, "_pending"}, sb.size(), 0);
  endtask

  task automatic runImage(input string name);
    logic       d, e;
    logic [1:0] c;
    modelImage(d, e, c);
    applyStimulus();
    checkOutput(name, d, e, c);
  endtask

  task automatic loadGood();
    imgBytes.delete();
    foreach (goodImg[i]) imgBytes.push_back(goodImg[i]);
  endtask

  initial begin
    logic [31:0] n;
    int          r;

    doReset();
    checkVal("rst_we", memWriteEnable, 0);
    checkVal("rst_addr", memAddress, 0);
    checkVal("rst_data", memWriteData, 0);
    checkVal("rst_cpuHold", cpuHold, 1);
    checkVal("rst_loading", loading, 1);
    checkVal("rst_done", done, 0);
    checkVal("rst_error", error, 0);
    checkVal("rst_code", errorCode, 0);

    loadGood();
    runImage("good");

    doReset();
    loadGood();
    imgBytes[12] = 8'h29;
    runImage("badsum");

    doReset();
    imgBytes.delete();
    repeat (5) imgBytes.push_back(8'h00);
    runImage("zero");

    doReset();
    imgBytes.delete();
    imgBytes.push_back(8'h05);
    repeat (3) imgBytes.push_back(8'h00);
    imgBytes.push_back(8'hAA);
    imgBytes.push_back(8'hBB);
    runImage("oversize");

    doReset();
    readyMode = 2;
    lowRun = 0;
    loadGood();
    runImage("stall");
    checkVal("stall_writes", waitLog.size(), 2);
    if (waitLog.size() > 0) checkVal("stall_cycles", waitLog[0], 4);
    readyMode = 0;

    doReset();
    readyMode = 1;
    loadGood();
    applyStimulus();
    checkOutput("overrun", 1'b0, 1'b1, 2'd2);
    readyMode = 0;

    doReset();
    for (int i = 0; i < 6; i++) sendByte(goodImg[i]);
    rxData = 8'h55;
    rxFin = 1'b1;
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    checkVal("async_we", memWriteEnable, 0);
    checkVal("async_loading", loading, 1);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (6) @(negedge clock);
    rxFin = 1'b0;
    repeat (5) @(negedge clock);
    loadGood();
    runImage("midreset");

    for (int k = 0; k < 24; k++) begin
      doReset();
      imgBytes.delete();
      r = $urandom_range(0, 9);
      if (r < 8) n = 32'(r % 5);
      else begin
        n = $urandom;
        if (n <= 32'(MAXW)) n = n + 32'd5;
      end
      imgBytes.push_back(n[7:0]);
      imgBytes.push_back(n[15:8]);
      imgBytes.push_back(n[23:16]);
      imgBytes.push_back(n[31:24]);
      if (n > 32'(MAXW)) begin
        repeat (2) imgBytes.push_back(8'($urandom));
      end else begin
        logic [7:0] x;
        repeat (4 * int'(n)) imgBytes.push_back(8'($urandom));
        x = 8'h00;
        foreach (imgBytes[i]) x = x ^ imgBytes[i];
        if ($urandom_range(0, 3) == 0) x = x ^ 8'($urandom_range(1, 255));
        imgBytes.push_back(x);
      end
      runImage($sformatf("rand%0d", k));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] timeout");
  end

endmodule
